// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Brief    : Sequential binary-to-BCD converter (double dabble, one bit per
//            clock) with leading-zero blank mask and overflow flag.
// Revision : 1.0 - initial release
// ============================================================================

module bin2bcd_seq #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank_mask,
  output logic                  ovf
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int ACC_W = 4 * DIGITS;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state;
  logic [BIN_W-1:0]   shreg;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_acc;

  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_next;
  logic [DIGITS-1:0]  mask_next;
  logic               ovf_next;

  // Add-3 correction on every digit in parallel before the shift
  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      assign acc_adj[4*g +: 4] = (acc[4*g +: 4] >= 4'd5) ? (acc[4*g +: 4] + 4'd3)
                                                         : acc[4*g +: 4];
    end
  endgenerate

  assign acc_next = {acc_adj[ACC_W-2:0], shreg[BIN_W-1]};
  assign ovf_next = ovf_acc | acc_adj[ACC_W-1];

  // A digit blanks only if it and every more-significant digit are zero
  always_comb begin
    logic all_zero;
    all_zero  = 1'b1;
    mask_next = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero     = all_zero & (acc_next[4*i +: 4] == 4'd0);
      mask_next[i] = all_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd_out    <= '0;
      blank_mask <= {{(DIGITS-1){1'b1}}, 1'b0};
      ovf        <= 1'b0;
      shreg      <= '0;
      acc        <= '0;
      cnt        <= '0;
      ovf_acc    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin_in;
            acc     <= '0;
            cnt     <= CNT_W'(BIN_W);
            ovf_acc <= 1'b0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          shreg   <= {shreg[BIN_W-2:0], 1'b0};
          acc     <= acc_next;
          ovf_acc <= ovf_next;
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            bcd_out    <= acc_next;
            blank_mask <= mask_next;
            ovf        <= ovf_next;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_seq
// Brief    : Self-checking bench for bin2bcd_seq (32/10 and 12/3 instances).
// Revision : 1.0 - initial release
// ============================================================================

module tb_bin2bcd_seq;

  typedef struct {
    logic [31:0] bin;
    logic [39:0] bcd;
    logic [9:0]  mask;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start2;
  logic [31:0] bin_in;
  logic [11:0] bin2;
  logic        busy, done, ovf, busy2, done2, ovf2;
  logic [39:0] bcd_out;
  logic [9:0]  blank_mask;
  logic [11:0] bcd2;
  logic [2:0]  mask2;

  int checks   = 0;
  int failures = 0;
  exp_t sbq[$];
  exp_t sbq2[$];
  exp_t em, em2;
  logic prev_done = 1'b0, prev_done2 = 1'b0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(32), .DIGITS(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .blank_mask(blank_mask), .ovf(ovf)
  );

  bin2bcd_seq #(.BIN_W(12), .DIGITS(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start2), .bin_in(bin2),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .blank_mask(mask2), .ovf(ovf2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, req);
    end
  endtask

  // Reference: decimal digits by repeated division
  function automatic exp_t model(input logic [31:0] v, input int nd);
    exp_t e;
    longint unsigned t;
    logic seen;
    e.bin  = v;
    e.bcd  = '0;
    e.mask = '0;
    t = longint'(v);
    for (int i = 0; i < nd; i++) begin
      e.bcd[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    e.ovf = (t != 0);
    seen = 1'b0;
    for (int i = nd - 1; i >= 1; i--) begin
      if (e.bcd[4*i +: 4] != 4'd0) seen = 1'b1;
      e.mask[i] = ~seen;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sbq.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          em = sbq.pop_front();
          chk("bcd_out", 64'(bcd_out), 64'(em.bcd));
          chk("blank_mask", 64'(blank_mask), 64'(em.mask));
          chk("ovf", 64'(ovf), 64'(em.ovf));
        end
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("done_width", 64'(prev_done), 64'd0);
      end
      if (done2) begin
        if (sbq2.size() == 0) chk("unexpected_done_s", 64'd1, 64'd0);
        else begin
          em2 = sbq2.pop_front();
          chk("bcd_out_s", 64'(bcd2), 64'(em2.bcd[11:0]));
          chk("blank_mask_s", 64'(mask2), 64'(em2.mask[2:0]));
          chk("ovf_s", 64'(ovf2), 64'(em2.ovf));
        end
        chk("busy_at_done_s", 64'(busy2), 64'd0);
      end
    end
    prev_done  = done;
    prev_done2 = done2;
  end

  task automatic run_vec(input exp_t e);
    int lat;
    @(negedge clk);
    start  = 1'b1;
    bin_in = e.bin;
    @(posedge clk); #1;
    start  = 1'b0;
    bin_in = $urandom;
    sbq.push_back(e);
    chk("busy_after_accept", 64'(busy), 64'd1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 100);
    chk("latency", 64'(lat), 64'd32);
  endtask

  task automatic run_small(input exp_t e);
    int lat;
    @(negedge clk);
    start2 = 1'b1;
    bin2   = e.bin[11:0];
    @(posedge clk); #1;
    start2 = 1'b0;
    bin2   = 12'($urandom);
    sbq2.push_back(e);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done2 && lat < 100);
    chk("latency_s", 64'(lat), 64'd12);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    exp_t vecs[8];
    exp_t e;
    int lat, cyc, last, seen;

    vecs[0] = '{32'd0,          40'h00_0000_0000, 10'h3FE, 1'b0};
    vecs[1] = '{32'd1234,       40'h00_0000_1234, 10'h3F0, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF,  40'h42_9496_7295, 10'h000, 1'b0};
    vecs[3] = '{32'd9,          40'h00_0000_0009, 10'h3FE, 1'b0};
    vecs[4] = '{32'd10,         40'h00_0000_0010, 10'h3FC, 1'b0};
    vecs[5] = '{32'd1000000000, 40'h10_0000_0000, 10'h000, 1'b0};
    vecs[6] = '{32'd99999,      40'h00_0009_9999, 10'h3E0, 1'b0};
    vecs[7] = '{32'd505,        40'h00_0000_0505, 10'h3F8, 1'b0};

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; bin_in = '0; bin2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bcd", 64'(bcd_out), 64'd0);
    chk("rst_mask", 64'(blank_mask), 64'h3FE);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_mask_s", 64'(mask2), 64'h6);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    for (int i = 0; i < 5; i++) run_vec(model($urandom, 10));

    // start and bin_in changes while busy must be ignored
    @(negedge clk);
    start = 1'b1; bin_in = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    sbq.push_back(model(32'd7, 10));
    repeat (4) @(posedge clk);
    #1; start = 1'b1; bin_in = 32'd99;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_ignore_start", 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("ignore_done_seen", 64'(done), 64'd1);
    repeat (40) @(negedge clk);
    chk("ignore_bcd_held", 64'(bcd_out), 64'h7);

    // reset mid-conversion aborts
    @(negedge clk);
    start = 1'b1; bin_in = 32'd500;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_bcd", 64'(bcd_out), 64'd0);
    chk("abort_mask", 64'(blank_mask), 64'h3FE);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_vec('{32'd42, 40'h00_0000_0042, 10'h3FC, 1'b0});

    // narrow instance: boundary of three digits and overflow
    run_small('{32'd999,  40'h999, 10'h000, 1'b0});
    run_small('{32'd1000, 40'h000, 10'h006, 1'b1});
    run_small(model(32'd4095, 3));
    run_small(model(32'd5, 3));

    // start held high: one conversion per 13 edges
    @(negedge clk);
    start2 = 1'b1; bin2 = 12'd999;
    for (int i = 0; i < 3; i++) sbq2.push_back(model(32'd999, 3));
    cyc = 0; last = -1; seen = 0;
    while (seen < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done2) begin
        seen++;
        if (last >= 0) chk("held_period", 64'(cyc - last), 64'd13);
        last = cyc;
        if (seen == 3) start2 = 1'b0;
      end
    end
    chk("held_done_count", 64'(seen), 64'd3);

    repeat (40) @(negedge clk);
    chk("sb_empty", 64'(sbq.size() + sbq2.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
